// File: rtl/ratio_bridge_pkg.sv
// Shared width helpers for the full-rate to 1/RATIO-rate stream bridge.
package ratio_bridge_pkg;

    // Integer type used for every derived width in the bridge
    typedef int width_t;

    // Bits needed for a phase counter that runs 0..ratio-1
    function automatic width_t phase_w(input width_t ratio);
        return width_t'($clog2(ratio));
    endfunction

    // Bits needed to report 0..depth+1 held words (FIFO plus output register)
    function automatic width_t level_w(input width_t depth);
        return width_t'($clog2(depth + 2));
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small power-of-two FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    // Storage: data words carry no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ratio_stream_bridge.sv
// Full-rate valid/ready stream in, 1/RATIO-rate stream out. Output beats only
// change on the last clk of a slow period (slow_ce) and are held otherwise.
module ratio_stream_bridge
    import ratio_bridge_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RATIO = 2,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        phase_sync,
    input  logic [WIDTH-1:0]            t0_data,
    input  logic                        t0_valid,
    output logic                        t0_ready,
    output logic [WIDTH-1:0]            i0_data,
    output logic                        i0_valid,
    input  logic                        i0_ready,
    output logic                        slow_ce,
    output logic [level_w(DEPTH)-1:0]   level
);
    localparam int PHASE_W = phase_w(RATIO);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int LEVEL_W = level_w(DEPTH);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(RATIO - 1);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               push;
    logic               take;
    logic               pop;
    logic [WIDTH-1:0]   fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               full_nxt;

    assign push = t0_valid && t0_ready;
    // The output register may take a new word when its current beat leaves or it is idle
    assign take = slow_ce && (!i0_valid || i0_ready);
    assign pop  = take && !fifo_empty;

    // Full after this edge: already full with nothing leaving, or one slot left being filled
    assign full_nxt = (fifo_full && !pop) ||
                      (push && !pop && (fifo_count == CNT_W'(DEPTH - 1)));

    assign level = LEVEL_W'(fifo_count) + LEVEL_W'(i0_valid);

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (t0_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next phase: phase_sync restarts the slow period and takes priority over the wrap
    always_comb begin
        phase_nxt = phase + PHASE_W'(1);
        if (phase_sync || (phase == PHASE_LAST)) begin
            phase_nxt = '0;
        end
    end

    // Phase counter with slow_ce registered so it is high exactly while phase is last
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            slow_ce <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            slow_ce <= (phase_nxt == PHASE_LAST);
        end
    end

    // Input acceptance: registered ready so an accepted word always has a slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t0_ready <= 1'b0;
        end else begin
            t0_ready <= !full_nxt;
        end
    end

    // Output register: loads the FIFO head or bubbles, only on slow_ce edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i0_valid <= 1'b0;
            i0_data  <= '0;
        end else if (take) begin
            if (!fifo_empty) begin
                i0_valid <= 1'b1;
                i0_data  <= fifo_rdata;
            end else begin
                i0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ratio_stream_bridge.sv
// Bench for ratio_stream_bridge: a RATIO=2 instance for the main stream tests and
// a RATIO=5 instance for phase_sync behaviour. Accepted words go into a queue and
// are compared in order against every output transfer.
`timescale 1ns/1ps
module tb_ratio_stream_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        phase_sync;
    logic [31:0] t0_data;
    logic        t0_valid;
    logic        t0_ready;
    logic [31:0] i0_data;
    logic        i0_valid;
    logic        i0_ready;
    logic        slow_ce;
    logic [2:0]  level;

    logic        ps5;
    logic [31:0] t5_data;
    logic        t5_valid;
    logic        t5_ready;
    logic [31:0] o5_data;
    logic        o5_valid;
    logic        o5_ready;
    logic        ce5;
    logic [2:0]  lvl5;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb[$];
    logic [31:0] sb5[$];
    int          out_cnt  = 0;
    int          out5_cnt = 0;
    int          lvl_max  = 0;
    logic        saw_stall = 1'b0;
    logic [2:0]  stall_lvl = '0;

    ratio_stream_bridge #(.WIDTH(32), .RATIO(2), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase_sync (phase_sync),
        .t0_data    (t0_data),
        .t0_valid   (t0_valid),
        .t0_ready   (t0_ready),
        .i0_data    (i0_data),
        .i0_valid   (i0_valid),
        .i0_ready   (i0_ready),
        .slow_ce    (slow_ce),
        .level      (level)
    );

    ratio_stream_bridge #(.WIDTH(32), .RATIO(5), .DEPTH(4)) dut5 (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase_sync (ps5),
        .t0_data    (t5_data),
        .t0_valid   (t5_valid),
        .t0_ready   (t5_ready),
        .i0_data    (o5_data),
        .i0_valid   (o5_valid),
        .i0_ready   (o5_ready),
        .slow_ce    (ce5),
        .level      (lvl5)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one word and hold it until accepted; returns at posedge+1
    task automatic send(input bit sel, input logic [31:0] w);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        if (sel) begin t5_data = w; t5_valid = 1'b1; end
        else     begin t0_data = w; t0_valid = 1'b1; end
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = sel ? t5_ready : t0_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        chk_eq(sel ? "send5_accept" : "send_accept", acc, 1'b1);
        if (sel) t5_valid = 1'b0;
        else     t0_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until every accepted word has left the bridge
    task automatic drain(input bit sel);
        int guard;
        guard = 0;
        while (guard < 300 &&
               (sel ? (sb5.size() != 0 || o5_valid) : (sb.size() != 0 || i0_valid))) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_eq(sel ? "drain5_empty" : "drain_empty", sel ? sb5.size() : sb.size(), 0);
    endtask

    // Monitor for the RATIO=2 instance
    logic        mon_ok = 1'b0;
    logic        prev_ce, prev_v;
    logic [31:0] prev_d;
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            mon_ok = 1'b0;
        end else begin
            if (mon_ok && !prev_ce) begin
                chk_eq("i0_hold_valid", i0_valid, prev_v);
                if (prev_v) chk_eq("i0_hold_data", i0_data, prev_d);
            end
            chk_eq("level_model", level, sb.size());
            if (t0_valid && t0_ready) sb.push_back(t0_data);
            if (t0_valid && !t0_ready && !saw_stall) begin
                saw_stall = 1'b1;
                stall_lvl = level;
            end
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (slow_ce && i0_valid && i0_ready) begin
                chk_eq("sb_has_word", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk_eq("i0_order", i0_data, sb.pop_front());
                out_cnt++;
            end
            prev_ce = slow_ce;
            prev_v  = i0_valid;
            prev_d  = i0_data;
            mon_ok  = 1'b1;
        end
    end

    // Monitor for the RATIO=5 instance
    logic        mon5_ok = 1'b0;
    logic        prev5_ce, prev5_v;
    logic [31:0] prev5_d;
    always @(negedge clk) begin
        if (!reset_n) begin
            sb5.delete();
            mon5_ok = 1'b0;
        end else begin
            if (mon5_ok && !prev5_ce) begin
                chk_eq("o5_hold_valid", o5_valid, prev5_v);
                if (prev5_v) chk_eq("o5_hold_data", o5_data, prev5_d);
            end
            chk_eq("level5_model", lvl5, sb5.size());
            if (t5_valid && t5_ready) sb5.push_back(t5_data);
            if (ce5 && o5_valid && o5_ready) begin
                chk_eq("sb5_has_word", sb5.size() != 0, 1'b1);
                if (sb5.size() != 0) chk_eq("o5_order", o5_data, sb5.pop_front());
                out5_cnt++;
            end
            prev5_ce = ce5;
            prev5_v  = o5_valid;
            prev5_d  = o5_data;
            mon5_ok  = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] words2 [5] = '{32'd2, 32'd20, 32'd0, 32'hDEADBEEF, 32'd7};

    initial begin
        int n;
        reset_n    = 1'b0;
        phase_sync = 1'b0;
        t0_data    = '0;
        t0_valid   = 1'b0;
        i0_ready   = 1'b1;
        ps5        = 1'b0;
        t5_data    = '0;
        t5_valid   = 1'b0;
        o5_ready   = 1'b1;

        // 1: reset values, then release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_i0_valid", i0_valid, 1'b0);
        chk_eq("rst_i0_data",  i0_data, 32'h0);
        chk_eq("rst_level",    level, 3'd0);
        chk_eq("rst_t0_ready", t0_ready, 1'b0);
        chk_eq("rst_slow_ce",  slow_ce, 1'b0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_eq("rel_t0_ready", t0_ready, 1'b1);
        chk_eq("rel_ce_1",     slow_ce, 1'b1);
        chk_eq("rel_i0_valid", i0_valid, 1'b0);
        chk_eq("rel_level",    level, 3'd0);
        @(negedge clk);
        chk_eq("rel_ce_2", slow_ce, 1'b0);
        @(negedge clk);
        chk_eq("rel_ce_3", slow_ce, 1'b1);
        @(posedge clk);
        #1;

        // 2: one word every 2 clk, consumer always ready
        out_cnt = 0;
        foreach (words2[i]) begin
            send(1'b0, words2[i]);
            idle(1);
        end
        drain(1'b0);
        chk_eq("t2_out_cnt", out_cnt, 5);

        // 3: back-to-back input, bridge must back-pressure at DEPTH+1 words
        out_cnt   = 0;
        lvl_max   = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 12; i++) send(1'b0, 32'h3000 + i);
        drain(1'b0);
        chk_eq("t3_saw_stall",  saw_stall, 1'b1);
        chk_eq("t3_stall_lvl",  stall_lvl, 3'd5);
        chk_eq("t3_level_peak", lvl_max, 5);
        chk_eq("t3_out_cnt",    out_cnt, 12);

        // 4: consumer stalls for 3 slow periods
        out_cnt  = 0;
        i0_ready = 1'b0;
        send(1'b0, 32'hA0);
        send(1'b0, 32'hA1);
        send(1'b0, 32'hA2);
        idle(4);
        chk_eq("t4_level_before", level, 3'd3);
        chk_eq("t4_valid_before", i0_valid, 1'b1);
        chk_eq("t4_data_before",  i0_data, 32'hA0);
        idle(6);
        chk_eq("t4_level_after", level, 3'd3);
        chk_eq("t4_data_after",  i0_data, 32'hA0);
        i0_ready = 1'b1;
        send(1'b0, 32'hA3);
        drain(1'b0);
        chk_eq("t4_out_cnt", out_cnt, 4);

        // 5: RATIO=5 instance, phase_sync in the middle of a slow period
        out5_cnt = 0;
        send(1'b1, 32'hB0);
        send(1'b1, 32'hB1);
        send(1'b1, 32'hB2);
        n = 0;
        while (!ce5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_eq("t5_ce_seen", ce5, 1'b1);
        idle(2);
        ps5 = 1'b1;
        @(posedge clk);
        #1 ps5 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ce5 && n < 20);
        chk_eq("t5_sync_gap", n, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ce5 && n < 20);
        chk_eq("t5_period", n, 5);
        @(posedge clk);
        #1;
        drain(1'b1);
        chk_eq("t5_out_cnt", out5_cnt, 3);

        // 6: reset while the bridge holds three words
        i0_ready = 1'b0;
        send(1'b0, 32'hC0);
        send(1'b0, 32'hC1);
        send(1'b0, 32'hC2);
        idle(4);
        chk_eq("t6_level_pre", level, 3'd3);
        #1 reset_n = 1'b0;
        #1;
        chk_eq("t6_rst_valid",  i0_valid, 1'b0);
        chk_eq("t6_rst_level",  level, 3'd0);
        chk_eq("t6_rst_ready",  t0_ready, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        i0_ready = 1'b1;
        out_cnt  = 0;
        send(1'b0, 32'hD0);
        send(1'b0, 32'hD1);
        send(1'b0, 32'hD2);
        drain(1'b0);
        chk_eq("t6_out_cnt", out_cnt, 3);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
